// File: rtl/config_reg_bank_if.sv
// Register bank access bus: write strobe, write data, shared address, read data.
// Ports: master drives write/data_in/address and samples data_out; slave is the reverse.
interface config_reg_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  write;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output write,
        output data_in,
        output address,
        input  data_out
    );

    modport slave (
        input  write,
        input  data_in,
        input  address,
        output data_out
    );
endinterface

// File: rtl/config_reg_bank.sv
// Eight-entry 16-bit configuration register file for the analog front-end
// control path, with one write port and one registered read port.
// Ports: clk (rising-edge clock), reset (synchronous, active-high),
//        bus (slave side: write, data_in, address in; data_out registered out).
module config_reg_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    config_reg_bank_if.slave      bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // Per-address power-on values: adc0, adc1, temp0, temp1,
    // analog_test, digital_test, amp_gain, digital_config.
    localparam logic [DATA_WIDTH-1:0] RESET_VALUES [NUM_REGS] = '{
        16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
        16'hABCD, 16'h0000, 16'h0000, 16'h0001
    };

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // The read uses the pre-edge contents, so a same-cycle write to the
    // addressed register is only visible on the following read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUES[i];
            end
            bus.data_out <= '0;
        end else begin
            bus.data_out <= regs[bus.address];
            if (bus.write) begin
                regs[bus.address] <= bus.data_in;
            end
        end
    end
endmodule

// File: tb/tb_config_reg_bank.sv
// Scoreboard bench for config_reg_bank: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural register-array model.
module tb_config_reg_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;

    config_reg_bank_if bus ();

    config_reg_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [8];
    logic [15:0] defaults [8];
    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;

    task automatic load_defaults();
        defaults[0] = 16'hFFFF;
        defaults[1] = 16'h0000;
        defaults[2] = 16'h0000;
        defaults[3] = 16'h0000;
        defaults[4] = 16'hABCD;
        defaults[5] = 16'h0000;
        defaults[6] = 16'h0000;
        defaults[7] = 16'h0001;
        for (int i = 0; i < 8; i++) model[i] = defaults[i];
    endtask

    // One clock of stimulus; the expected data_out after the coming edge
    // is what the model holds before this cycle's write is applied.
    task automatic step(input logic rst, input logic wr,
                        input logic [2:0] addr, input logic [15:0] din);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        bus.write   = wr;
        bus.address = addr;
        bus.data_in = din;
        cyc++;
        e.exp = rst ? 16'h0000 : model[addr];
        e.cyc = cyc;
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = defaults[i];
        end else if (wr) begin
            model[addr] = din;
        end
    endtask

    // Monitor: data_out is presented after every edge, so each edge
    // retires one outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.data_out === e.exp) begin
                    passed++;
                end else begin
                    $display("FAIL data_out cyc=%0d got=%h exp=%h",
                             e.cyc, bus.data_out, e.exp);
                end
            end
        end
    end

    initial begin
        logic [2:0] a;
        bus.write   = 1'b0;
        bus.address = 3'd0;
        bus.data_in = 16'h0000;
        load_defaults();

        // Reset defaults
        step(1, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h0000);
        for (int i = 0; i < 8; i++) step(0, 0, 3'(i), 16'h0000);

        // Write/readback
        step(0, 1, 4, 16'h0FFF);
        step(0, 1, 5, 16'h2525);
        step(0, 0, 4, 16'h0000);
        step(0, 0, 5, 16'h0000);
        step(0, 0, 6, 16'h0000);

        // Amplifier gain
        step(0, 1, 6, 16'h2525);
        step(0, 0, 6, 16'h0000);
        step(0, 0, 7, 16'h0000);

        // Read-during-write
        step(1, 0, 0, 16'h0000);
        step(0, 1, 0, 16'h1234);
        step(0, 0, 0, 16'h0000);

        // Reset mid-operation
        for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 16'hBEEF);
        step(1, 1, 2, 16'h5555);
        step(1, 1, 7, 16'h5555);
        for (int i = 0; i < 8; i++) step(0, 0, 3'(i), 16'h0000);

        // Retention
        step(0, 1, 3, 16'hA5A5);
        for (int i = 0; i < 50; i++) begin
            a = 3'($urandom_range(0, 7));
            if (a == 3'd3) a = 3'd4;
            step(0, 0, a, 16'($urandom));
        end
        step(0, 0, 3, 16'h0000);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 16'($urandom));
        end
        step(0, 0, 0, 16'h0000);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
